// File: rtl/cic_pkg.sv
// Shared helpers and legal-range limits for the CIC decimator.
package cic_pkg;

  localparam int unsigned CIC_MAX_ORDER = 6;
  localparam int unsigned CIC_MAX_RATE  = 256;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Internal register width needed so the full DC gain RATE^ORDER never overflows.
  function automatic int unsigned cic_width(input int unsigned order, input int unsigned rate,
                                            input int unsigned in_w);
    return in_w + order * clog2(rate);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y <= x - x_prev, updated only when en is high.
module cic_comb_stage #(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] d_q;
  logic signed [W-1:0] y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
      y_q <= '0;
    end else if (en) begin
      y_q <= x - d_q;
      d_q <= x;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/cic_decim.sv
// Parametrised CIC decimator with valid-qualified input and scaled output.
// Define CIC_DECIM_ROUND_EN to round half up instead of truncating when OUT_W < W.
module cic_decim
  import cic_pkg::*;
#(
  parameter int unsigned ORDER = 3,
  parameter int unsigned RATE  = 8,
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in,
  input  logic                    valid_in,
  output logic signed [OUT_W-1:0] out,
  output logic                    valid_out
);

  localparam int unsigned W     = cic_width(ORDER, RATE, IN_W);
  localparam int unsigned CNT_W = clog2(RATE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

  logic signed [W-1:0]     in_ext;
  logic signed [W-1:0]     integ_q [ORDER];
  logic [CNT_W-1:0]        cnt_q;
  logic [ORDER:0]          strobe_q;
  logic signed [W-1:0]     comb_y [ORDER+1];
  logic signed [W-1:0]     c_last;
  logic signed [OUT_W-1:0] scaled;

  assign in_ext = W'(in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < ORDER; j++) integ_q[j] <= '0;
    end else if (valid_in) begin
      integ_q[0] <= integ_q[0] + in_ext;
      for (int j = 1; j < ORDER; j++) integ_q[j] <= integ_q[j] + integ_q[j-1];
    end
  end

  // Strobes are shift-separated, so each comb stage sees at most one update per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      strobe_q <= '0;
    end else begin
      strobe_q <= {strobe_q[ORDER-1:0], valid_in && (cnt_q == CNT_LAST)};
      if (valid_in) cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign comb_y[0] = integ_q[ORDER-1];

  for (genvar j = 0; j < ORDER; j++) begin : g_comb
    cic_comb_stage #(
      .W(W)
    ) u_comb (
      .clk(clk),
      .rst(rst),
      .en (strobe_q[j]),
      .x  (comb_y[j]),
      .y  (comb_y[j+1])
    );
  end

  assign c_last = comb_y[ORDER];

  if (OUT_W >= W) begin : g_extend
    assign scaled = OUT_W'(c_last);
  end else begin : g_shift
    localparam int unsigned SH = W - OUT_W;
`ifdef CIC_DECIM_ROUND_EN
    localparam logic signed [W:0] HALF = (W+1)'(1) <<< (SH - 1);
    logic signed [W:0] rounded;
    logic              unused_round_bits;
    assign rounded           = (W+1)'(c_last) + HALF;
    assign scaled            = rounded[W-1 -: OUT_W];
    assign unused_round_bits = ^{rounded[W], rounded[SH-1:0]};
`else
    logic unused_lsbs;
    assign scaled      = c_last[W-1 -: OUT_W];
    assign unused_lsbs = ^c_last[SH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= strobe_q[ORDER];
      if (strobe_q[ORDER]) out <= scaled;
    end
  end

endmodule

// File: tb/tb_cic_decim.sv
// Self-checking bench for cic_decim: directed and random stimulus against an arithmetic CIC model.
module tb_cic_decim;

  localparam int unsigned ORDER  = 3;
  localparam int unsigned RATE   = 8;
  localparam int unsigned IN_W   = 2;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned OUT_W8 = 8;
  localparam int unsigned W      = 11;
  localparam int unsigned SH8    = W - OUT_W8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic signed [IN_W-1:0]   in_s = '0;
  logic signed [OUT_W-1:0]  out16;
  logic                     vout16;
  logic signed [OUT_W8-1:0] out8;
  logic                     vout8;

  cic_decim #(.ORDER(ORDER), .RATE(RATE), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in(in_s), .valid_in(valid_in), .out(out16), .valid_out(vout16)
  );

  cic_decim #(.ORDER(ORDER), .RATE(RATE), .IN_W(IN_W), .OUT_W(OUT_W8)) dut8 (
    .clk(clk), .rst(rst), .in(in_s), .valid_in(valid_in), .out(out8), .valid_out(vout8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  int hist[$];
  int acc_cyc[$];
  int obs16[$];
  int obs8[$];
  int vcyc[$];
  int checked = 0;
  int rst_err = 0;
  int consec  = 0;
  int vsync_err = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst && (vout16 || vout8 || out16 != 0 || out8 != 0)) rst_err++;
    if (vout16 && prev_v) consec++;
    if (vout16 !== vout8) vsync_err++;
    if (vout16) begin
      obs16.push_back(int'(out16));
      obs8.push_back(int'(out8));
      vcyc.push_back(cyc);
    end
    prev_v = vout16;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Integrator cascade value after n accepted samples: ORDER nested running sums.
  function automatic longint integ_at(input int n);
    longint cur[];
    longint nxt[];
    cur = new[n+1];
    cur[0] = 0;
    for (int t = 1; t <= n; t++) cur[t] = cur[t-1] + longint'(hist[t-1]);
    for (int j = 2; j <= int'(ORDER); j++) begin
      nxt = new[n+1];
      nxt[0] = 0;
      for (int t = 1; t <= n; t++) nxt[t] = nxt[t-1] + cur[t-1];
      cur = nxt;
    end
    return cur[n];
  endfunction

  function automatic longint binom(input int n, input int k);
    longint r;
    r = 1;
    for (int i = 1; i <= k; i++) r = r * longint'(n - k + i) / longint'(i);
    return r;
  endfunction

  // Decimated output m (1-based): ORDER-th finite difference of the decimated integrator, wrapped.
  function automatic longint model_c(input int m);
    longint acc;
    longint term;
    acc = 0;
    for (int k = 0; k <= int'(ORDER); k++) begin
      if (m - k > 0) begin
        term = binom(ORDER, k) * integ_at((m - k) * RATE);
        acc  = (k % 2 == 1) ? acc - term : acc + term;
      end
    end
    acc = acc & ((64'sd1 <<< W) - 1);
    if (acc >= (64'sd1 <<< (W - 1))) acc = acc - (64'sd1 <<< W);
    return acc;
  endfunction

  function automatic int exp8(input longint c);
    longint     q;
    logic [7:0] b;
`ifdef CIC_DECIM_ROUND_EN
    q = (c + (64'sd1 <<< (SH8 - 1))) >>> SH8;
`else
    q = c >>> SH8;
`endif
    b = q[7:0];
    return int'($signed(b));
  endfunction

  function automatic int last16();
    return (obs16.size() > 0) ? obs16[obs16.size()-1] : -99999;
  endfunction

  function automatic int last8();
    return (obs8.size() > 0) ? obs8[obs8.size()-1] : -99999;
  endfunction

  function automatic int rnd_in();
    return int'($urandom_range(0, 3)) - 2;
  endfunction

  task automatic step(input logic v, input int d);
    @(negedge clk);
    valid_in = v;
    in_s     = IN_W'(d);
    if (v && !rst) begin
      hist.push_back(d);
      acc_cyc.push_back(cyc + 1);
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) step(1'($urandom_range(0, 1)), rnd_in());
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    hist.delete();
    acc_cyc.delete();
    obs16.delete();
    obs8.delete();
    vcyc.delete();
    checked = 0;
  endtask

  task automatic drain();
    repeat (12) step(1'b0, 0);
  endtask

  task automatic score(input string tag);
    int     m;
    int     want_cyc;
    longint c;
    for (int i = checked; i < obs16.size(); i++) begin
      m = i + 1;
      c = model_c(m);
      want_cyc = (m * RATE <= acc_cyc.size()) ? acc_cyc[m*RATE-1] + ORDER + 1 : -1;
      check({tag, "/out16"}, obs16[i], int'(c));
      check({tag, "/out8"}, obs8[i], exp8(c));
      check({tag, "/latency"}, vcyc[i], want_cyc);
    end
    checked = obs16.size();
    check({tag, "/count"}, obs16.size(), hist.size() / RATE);
  endtask

  initial begin
    int bad;
    int nb;

    // Reset held with toggling inputs.
    apply_reset(12);
    check("rst/quiet", rst_err, 0);
    check("rst/out", int'(out16), 0);
    check("rst/valid", int'(vout16), 0);
    release_reset();

    // DC +1, continuous.
    repeat (200) step(1'b1, 1);
    drain();
    score("dc_pos");
    check("dc_pos/4th", (obs16.size() > 3) ? obs16[3] : -99999, 512);
    check("dc_pos/last", last16(), 512);
    check("dc_pos/last8", last8(), 64);
    bad = 0;
    for (int i = 1; i < vcyc.size(); i++) if (vcyc[i] - vcyc[i-1] != int'(RATE)) bad++;
    check("dc_pos/period", bad, 0);

    // DC -1, continuous.
    repeat (200) step(1'b1, -1);
    drain();
    score("dc_neg");
    check("dc_neg/last", last16(), -512);
    check("dc_neg/last8", last8(), -64);

    // Gapped valid: one accept in three cycles.
    repeat (80) begin
      step(1'b1, 1);
      step(1'b0, 0);
      step(1'b0, 0);
    end
    drain();
    score("gapped");
    check("gapped/last", last16(), 512);
    check("gapped/consec", consec, 0);

    // Random samples and random valid gaps.
    repeat (200) step(1'($urandom_range(0, 1)), rnd_in());
    drain();
    score("random");

    // Alternating +1/-1.
    for (int i = 0; i < 160; i++) step(1'b1, (i % 2 == 0) ? 1 : -1);
    drain();
    score("alt");
    check("alt/last", last16(), 0);

    // Pattern giving C_ORDER = +5 on the first output.
    apply_reset(3);
    release_reset();
    foreach (hist[i]) begin end
    step(1'b1, 0); step(1'b1, 0); step(1'b1, 0); step(1'b1, 1);
    step(1'b1, 0); step(1'b1, -1); step(1'b1, 0); step(1'b1, 0);
    drain();
    score("c_pos5");
    check("c_pos5/out16", (obs16.size() > 0) ? obs16[0] : -99999, 5);
`ifdef CIC_DECIM_ROUND_EN
    check("c_pos5/out8", (obs8.size() > 0) ? obs8[0] : -99999, 1);
`else
    check("c_pos5/out8", (obs8.size() > 0) ? obs8[0] : -99999, 0);
`endif

    // Pattern giving C_ORDER = -5 on the first output.
    apply_reset(3);
    release_reset();
    step(1'b1, 0); step(1'b1, 0); step(1'b1, 0); step(1'b1, -1);
    step(1'b1, 0); step(1'b1, 1); step(1'b1, 0); step(1'b1, 0);
    drain();
    score("c_neg5");
    check("c_neg5/out16", (obs16.size() > 0) ? obs16[0] : -99999, -5);
    check("c_neg5/out8", (obs8.size() > 0) ? obs8[0] : -99999, -1);

    // Reset two cycles after a cnt == RATE-1 accept discards the in-flight strobe.
    apply_reset(3);
    release_reset();
    repeat (16) step(1'b1, 1);
    repeat (2) step(1'b0, 0);
    nb = obs16.size();
    check("midrst/before", nb, 1);
    apply_reset(5);
    check("midrst/held", obs16.size(), nb);
    release_reset();
    repeat (8) step(1'b0, 0);
    check("midrst/flushed", obs16.size(), 0);
    repeat (100) step(1'b1, 1);
    drain();
    score("midrst");
    check("midrst/last", last16(), 512);

    check("global/rst_quiet", rst_err, 0);
    check("global/consec", consec, 0);
    check("global/vsync", vsync_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
